// File: rtl/tri_raster_scanner_if.sv
// Pixel sink handshake between tri_raster_scanner (master) and the downstream pixel consumer (slave).
interface tri_raster_scanner_if #(
  parameter int evalBits = 8,
  parameter int lambdaW  = 13
);
  logic                      pix_valid;
  logic                      pix_ready;
  logic        [evalBits-1:0] pix_x;
  logic        [evalBits-1:0] pix_y;
  logic signed [lambdaW-1:0]  pix_l0;
  logic signed [lambdaW-1:0]  pix_l1;
  logic signed [lambdaW-1:0]  pix_l2;

  modport master (output pix_valid, pix_x, pix_y, pix_l0, pix_l1, pix_l2, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_l0, pix_l1, pix_l2, output pix_ready);
endinterface

// File: rtl/tri_raster_scanner.sv
// Triangle bounding-box scanner: drives BaricentricCoords and forwards covered pixels to a sink.
// Optional macro RASTER_BACKFACE_CULL_EN: also cull clockwise (negative-area) triangles.
module tri_raster_scanner #(
  parameter int evalBits    = 8,
  parameter int intBits     = 4,
  parameter int decimalBits = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic signed [intBits:0]               x_0,
  input  logic signed [intBits:0]               y_0,
  input  logic signed [intBits:0]               x_1,
  input  logic signed [intBits:0]               y_1,
  input  logic signed [intBits:0]               x_2,
  input  logic signed [intBits:0]               y_2,
  output logic                                  busy,
  output logic                                  done,
  output logic        [evalBits-1:0]            evalX,
  output logic        [evalBits-1:0]            evalY,
  input  logic                                  inTris,
  input  logic signed [intBits+decimalBits:0]   lambda_0,
  input  logic signed [intBits+decimalBits:0]   lambda_1,
  input  logic signed [intBits+decimalBits:0]   lambda_2,
  tri_raster_scanner_if.master                  pix
);
  localparam int AW   = 2*intBits + 3;
  localparam int MAXC = (2**evalBits) - 1;

  typedef enum logic [2:0] {IDLE, SETUP, SCAN, EMIT, DONE} state_t;

  state_t state, state_nxt;
  logic   load, setup, capture, advance, last, cull;

  logic signed [intBits:0]  x0_r, y0_r, x1_r, y1_r, x2_r, y2_r;
  logic        [evalBits-1:0] xmin, xmax, ymin, ymax;
  logic signed [AW-1:0]     dx1, dy1, dx2, dy2, area;

  function automatic logic signed [intBits:0] min3(input logic signed [intBits:0] a, b, c);
    logic signed [intBits:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [intBits:0] max3(input logic signed [intBits:0] a, b, c);
    logic signed [intBits:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Saturate a signed vertex coordinate into the unsigned scan range.
  function automatic logic [evalBits-1:0] clamp_coord(input logic signed [intBits:0] v);
    if (v < 0)             return '0;
    else if (int'(v) > MAXC) return evalBits'(MAXC);
    else                   return evalBits'(int'(v));
  endfunction

  assign xmin = clamp_coord(min3(x0_r, x1_r, x2_r));
  assign xmax = clamp_coord(max3(x0_r, x1_r, x2_r));
  assign ymin = clamp_coord(min3(y0_r, y1_r, y2_r));
  assign ymax = clamp_coord(max3(y0_r, y1_r, y2_r));

  assign dx1  = AW'(x1_r) - AW'(x0_r);
  assign dy1  = AW'(y1_r) - AW'(y0_r);
  assign dx2  = AW'(x2_r) - AW'(x0_r);
  assign dy2  = AW'(y2_r) - AW'(y0_r);
  assign area = dx1*dy2 - dx2*dy1;

`ifdef RASTER_BACKFACE_CULL_EN
  assign cull = (area == '0) || area[AW-1];
`else
  assign cull = (area == '0);
`endif

  assign last = (evalX == xmax) && (evalY == ymax);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    setup     = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE:  if (start) begin
               load      = 1'b1;
               state_nxt = SETUP;
             end
      SETUP: begin
               setup     = 1'b1;
               state_nxt = cull ? DONE : SCAN;
             end
      SCAN:  if (inTris) begin
               capture   = 1'b1;
               state_nxt = EMIT;
             end else begin
               advance   = !last;
               state_nxt = last ? DONE : SCAN;
             end
      EMIT:  if (pix.pix_ready) begin
               advance   = !last;
               state_nxt = last ? DONE : SCAN;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vertex latch: only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      x0_r <= x_0;  y0_r <= y_0;
      x1_r <= x_1;  y1_r <= y_1;
      x2_r <= x_2;  y2_r <= y_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      evalX         <= '0;
      evalY         <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_x     <= '0;
      pix.pix_y     <= '0;
      pix.pix_l0    <= '0;
      pix.pix_l1    <= '0;
      pix.pix_l2    <= '0;
    end else begin
      state <= state_nxt;
      if (setup) begin
        evalX <= xmin;
        evalY <= ymin;
      end else if (advance) begin
        if (evalX < xmax) begin
          evalX <= evalX + 1'b1;
        end else begin
          evalX <= xmin;
          evalY <= evalY + 1'b1;
        end
      end
      if (capture) begin
        pix.pix_valid <= 1'b1;
        pix.pix_x     <= evalX;
        pix.pix_y     <= evalY;
        pix.pix_l0    <= lambda_0;
        pix.pix_l1    <= lambda_1;
        pix.pix_l2    <= lambda_2;
      end else if (state == EMIT && pix.pix_ready) begin
        pix.pix_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tri_raster_scanner.sv
// Directed bench for tri_raster_scanner with a behavioural BaricentricCoords stage and pixel sink.
module tb_tri_raster_scanner;
  localparam int EB = 8;
  localparam int IB = 4;
  localparam int DB = 8;
  localparam int LW = IB + DB + 1;
  localparam int VW = IB + 1;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [VW-1:0] x_0, y_0, x_1, y_1, x_2, y_2;
  logic busy, done;
  logic [EB-1:0] evalX, evalY;
  logic inTris;
  logic signed [LW-1:0] lambda_0, lambda_1, lambda_2;

  int vx0, vy0, vx1, vy1, vx2, vy2;
  int m_px, m_py, m_a, m_w0, m_w1, m_w2;
  int errors = 0;
  int checks = 0;
  int gx[$], gy[$], g0[$], g1[$], g2[$];
  int ex[$], ey[$], e0[$], e1[$], e2[$];

  tri_raster_scanner_if #(.evalBits(EB), .lambdaW(LW)) pif ();

  tri_raster_scanner #(.evalBits(EB), .intBits(IB), .decimalBits(DB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_0(x_0), .y_0(y_0), .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
    .busy(busy), .done(done), .evalX(evalX), .evalY(evalY),
    .inTris(inTris), .lambda_0(lambda_0), .lambda_1(lambda_1), .lambda_2(lambda_2),
    .pix(pif)
  );

  always #5 clk = ~clk;

  // Behavioural BaricentricCoords: edge functions, coverage by sign, lambdas scaled by 2^DB.
  always_comb begin
    m_px = int'(evalX);
    m_py = int'(evalY);
    m_a  = (vx1-vx0)*(vy2-vy0) - (vx2-vx0)*(vy1-vy0);
    m_w1 = (m_px-vx0)*(vy2-vy0) - (vx2-vx0)*(m_py-vy0);
    m_w2 = (vx1-vx0)*(m_py-vy0) - (m_px-vx0)*(vy1-vy0);
    m_w0 = m_a - m_w1 - m_w2;
    inTris   = 1'b0;
    lambda_0 = '0;
    lambda_1 = '0;
    lambda_2 = '0;
    if (m_a != 0) begin
      if (m_a > 0) inTris = (m_w0 >= 0) && (m_w1 >= 0) && (m_w2 >= 0);
      else         inTris = (m_w0 <= 0) && (m_w1 <= 0) && (m_w2 <= 0);
      lambda_0 = LW'((m_w0 * 256) / m_a);
      lambda_1 = LW'((m_w1 * 256) / m_a);
      lambda_2 = LW'((m_w2 * 256) / m_a);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pixels of the right triangle with legs lim, row-major; swap mirrors the winding.
  task automatic build_exp(input int lim, input bit swap);
    ex.delete(); ey.delete(); e0.delete(); e1.delete(); e2.delete();
    for (int y = 0; y <= lim; y++)
      for (int x = 0; x <= lim; x++)
        if (x + y <= lim) begin
          ex.push_back(x); ey.push_back(y);
          e0.push_back(256 - 64*(x+y));
          e1.push_back(swap ? 64*y : 64*x);
          e2.push_back(swap ? 64*x : 64*y);
        end
  endtask

  // Start a triangle and act as the pixel sink until done (or until stop_pix pixels are pending).
  task automatic run_tri(input int a0, b0, a1, b1, a2, b2, input bit rnd, input int stop_pix,
                         output int dcyc);
    int cyc;
    bit held, rdy;
    logic [EB-1:0] hx, hy;
    logic signed [LW-1:0] h0, h1, h2;
    gx.delete(); gy.delete(); g0.delete(); g1.delete(); g2.delete();
    dcyc = -1;
    held = 1'b0;
    @(negedge clk);
    vx0 = a0; vy0 = b0; vx1 = a1; vy1 = b1; vx2 = a2; vy2 = b2;
    x_0 = VW'(a0); y_0 = VW'(b0); x_1 = VW'(a1); y_1 = VW'(b1); x_2 = VW'(a2); y_2 = VW'(b2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (dcyc < 0 && cyc <= 400) begin
      if (held) begin
        checks++;
        if (!pif.pix_valid ||
            {pif.pix_x, pif.pix_y, pif.pix_l0, pif.pix_l1, pif.pix_l2} !== {hx, hy, h0, h1, h2}) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d: got v=%0b (%0d,%0d) want held (%0d,%0d)",
                   cyc, pif.pix_valid, pif.pix_x, pif.pix_y, hx, hy);
        end
      end
      held = 1'b0;
      rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        dcyc = cyc;
        pif.pix_ready = 1'b0;
      end else if (pif.pix_valid && stop_pix > 0 && gx.size() == stop_pix - 1) begin
        pif.pix_ready = 1'b0;
        dcyc = cyc;
      end else begin
        pif.pix_ready = rdy;
        if (pif.pix_valid && rdy) begin
          gx.push_back(int'(pif.pix_x)); gy.push_back(int'(pif.pix_y));
          g0.push_back(int'(pif.pix_l0)); g1.push_back(int'(pif.pix_l1)); g2.push_back(int'(pif.pix_l2));
        end else if (pif.pix_valid) begin
          held = 1'b1;
          hx = pif.pix_x; hy = pif.pix_y; h0 = pif.pix_l0; h1 = pif.pix_l1; h2 = pif.pix_l2;
        end
      end
      if (dcyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", cyc - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pif.pix_ready = 1'b0;
    x_0 = '0; y_0 = '0; x_1 = '0; y_1 = '0; x_2 = '0; y_2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, pif.pix_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got busy,done,valid=%b want 000", {busy, done, pif.pix_valid});
    end
    checks++;
    if ({evalX, evalY, pif.pix_x, pif.pix_y} !== 32'd0) begin
      errors++; $display("FAIL reset_coords: got evalX=%0d evalY=%0d pix=(%0d,%0d) want 0", evalX, evalY, pif.pix_x, pif.pix_y);
    end
    checks++;
    if ({pif.pix_l0, pif.pix_l1, pif.pix_l2} !== '0) begin
      errors++; $display("FAIL reset_lambda: got %0d %0d %0d want 0", pif.pix_l0, pif.pix_l1, pif.pix_l2);
    end
  endtask

  task automatic test_basic();
    int dc;
    build_exp(4, 1'b0);
    run_tri(0, 0, 4, 0, 0, 4, 1'b0, 0, dc);
    checks++;
    if (gx.size() != 15) begin errors++; $display("FAIL basic_count: got %0d want 15", gx.size()); end
    for (int i = 0; i < ex.size() && i < gx.size(); i++) begin
      checks++;
      if ({gx[i], gy[i], g0[i], g1[i], g2[i]} !== {ex[i], ey[i], e0[i], e1[i], e2[i]}) begin
        errors++;
        $display("FAIL basic_pix%0d: got (%0d,%0d) l=%0d,%0d,%0d want (%0d,%0d) l=%0d,%0d,%0d",
                 i, gx[i], gy[i], g0[i], g1[i], g2[i], ex[i], ey[i], e0[i], e1[i], e2[i]);
      end
    end
    checks++;
    if (dc != 42) begin errors++; $display("FAIL basic_done_cycle: got %0d want 42", dc); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_after: got busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_stall();
    int dc;
    build_exp(4, 1'b0);
    run_tri(0, 0, 4, 0, 0, 4, 1'b1, 0, dc);
    checks++;
    if (gx.size() != 15) begin errors++; $display("FAIL stall_count: got %0d want 15", gx.size()); end
    for (int i = 0; i < ex.size() && i < gx.size(); i++) begin
      checks++;
      if ({gx[i], gy[i], g0[i], g1[i], g2[i]} !== {ex[i], ey[i], e0[i], e1[i], e2[i]}) begin
        errors++;
        $display("FAIL stall_pix%0d: got (%0d,%0d) l0=%0d want (%0d,%0d) l0=%0d", i, gx[i], gy[i], g0[i], ex[i], ey[i], e0[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_degenerate();
    int dc;
    run_tri(0, 0, 2, 2, 4, 4, 1'b0, 0, dc);
    checks++;
    if (dc != 2 || gx.size() != 0) begin
      errors++; $display("FAIL degen: got done@%0d pixels=%0d want done@2 pixels=0", dc, gx.size());
    end
    // start raised while done is high must be ignored
    x_0 = VW'(0); y_0 = VW'(0); x_1 = VW'(4); y_1 = VW'(0); x_2 = VW'(0); y_2 = VW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL done_pulse: got busy,done=%b want 00", {busy, done}); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b want 0", busy); end
  endtask

  task automatic test_clamp();
    int dc;
    bit bad;
    run_tri(-3, -3, 3, 0, 0, 3, 1'b0, 0, dc);
    checks++;
    if (gx.size() != 10) begin errors++; $display("FAIL clamp_count: got %0d want 10", gx.size()); end
    bad = 1'b0;
    for (int i = 0; i < gx.size(); i++) if (gx[i] > 3 || gy[i] > 3) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL clamp_range: got pixel outside 0..3 want inside"); end
    checks++;
    if (gx.size() > 0 && {gx[0], gy[0], g0[0]} !== {32'sd0, 32'sd0, 32'sd85}) begin
      errors++; $display("FAIL clamp_first: got (%0d,%0d) l0=%0d want (0,0) l0=85", gx[0], gy[0], g0[0]);
    end
    checks++;
    if (dc != 28) begin errors++; $display("FAIL clamp_done_cycle: got %0d want 28", dc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc;
    run_tri(0, 0, 4, 0, 0, 4, 1'b0, 5, dc);
    checks++;
    if (gx.size() != 4 || pif.pix_valid !== 1'b1 || pif.pix_x !== 8'd4) begin
      errors++; $display("FAIL midrst_setup: got accepted=%0d valid=%b x=%0d want 4 1 4", gx.size(), pif.pix_valid, pif.pix_x);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({pif.pix_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_abort: got valid,busy=%b want 00", {pif.pix_valid, busy});
    end
    @(negedge clk);
    checks++;
    if (pif.pix_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got valid=%b want 0", pif.pix_valid); end
    build_exp(4, 1'b0);
    run_tri(0, 0, 4, 0, 0, 4, 1'b0, 0, dc);
    checks++;
    if (gx.size() != 15 || dc != 42) begin
      errors++; $display("FAIL midrst_rerun: got pixels=%0d done@%0d want 15 done@42", gx.size(), dc);
    end
    for (int i = 0; i < ex.size() && i < gx.size(); i++) begin
      checks++;
      if ({gx[i], gy[i], g0[i]} !== {ex[i], ey[i], e0[i]}) begin
        errors++; $display("FAIL midrst_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, gx[i], gy[i], ex[i], ey[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_winding();
    int dc;
    run_tri(0, 0, 0, 4, 4, 0, 1'b0, 0, dc);
`ifdef RASTER_BACKFACE_CULL_EN
    checks++;
    if (dc != 2 || gx.size() != 0) begin
      errors++; $display("FAIL cw_cull: got done@%0d pixels=%0d want done@2 pixels=0", dc, gx.size());
    end
`else
    build_exp(4, 1'b1);
    checks++;
    if (gx.size() != 15 || dc != 42) begin
      errors++; $display("FAIL cw_scan: got pixels=%0d done@%0d want 15 done@42", gx.size(), dc);
    end
    for (int i = 0; i < ex.size() && i < gx.size(); i++) begin
      checks++;
      if ({gx[i], gy[i], g0[i], g1[i], g2[i]} !== {ex[i], ey[i], e0[i], e1[i], e2[i]}) begin
        errors++;
        $display("FAIL cw_pix%0d: got (%0d,%0d) l=%0d,%0d,%0d want (%0d,%0d) l=%0d,%0d,%0d",
                 i, gx[i], gy[i], g0[i], g1[i], g2[i], ex[i], ey[i], e0[i], e1[i], e2[i]);
      end
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    vx0 = 0; vy0 = 0; vx1 = 0; vy1 = 0; vx2 = 0; vy2 = 0;
    test_reset();
    test_basic();
    test_stall();
    test_degenerate();
    test_clamp();
    test_reset_mid();
    test_winding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
